pixel_raster_tagger: RTL

- Streaming front-end that feeds the cropping stage.
- Accepts a raw 8-bit grayscale pixel stream in raster order over a valid/ready handshake and tags each pixel with column/row coordinates and frame markers (sof, eol, eof).
- Counts exactly ROWS*COLS pixels per armed frame, then drains and reports completion.
- The downstream crop stage selects pixels purely from m_x/m_y, with no file-based full-frame storage.

---
 rtl/pixel_raster_tagger.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/pixel_raster_tagger.sv
`default_nettype none
// ============================================================================
// Module      : pixel_raster_tagger
// Description : Tags a raster-order 8-bit pixel stream with x/y coordinates
//               and sof/eol/eof markers, one armed frame at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_raster_tagger #(
  parameter int ROWS = 512,
  parameter int COLS = 512,
  parameter int CW   = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [7:0]    s_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [7:0]    m_data,
  output logic [CW-1:0] m_x,
  output logic [CW-1:0] m_y,
  output logic          m_sof,
  output logic          m_eol,
  output logic          m_eof,
  output logic          busy,
  output logic          frame_done,
  output logic [15:0]   frame_count
);

  localparam int            PW       = 8 + 2 * CW + 3;
  localparam logic [CW-1:0] c_last_x = CW'(COLS - 1);
  localparam logic [CW-1:0] c_last_y = CW'(ROWS - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_x;
  logic [CW-1:0] r_y;
  logic [PW-1:0] r_main;
  logic [PW-1:0] r_skid;
  logic          r_main_valid;
  logic          r_skid_valid;
  logic          r_s_ready;
  logic          r_frame_done;
  logic [15:0]   r_frame_count;

  logic          w_in_xfer;
  logic          w_out_xfer;
  logic          w_main_open;
  logic          w_sof;
  logic          w_eol;
  logic          w_eof;
  logic          w_skid_valid_nxt;
  logic [PW-1:0] w_in_word;

  assign w_in_xfer   = s_valid & r_s_ready;
  assign w_out_xfer  = r_main_valid & m_ready;
  assign w_main_open = ~r_main_valid | w_out_xfer;

  // Markers come from the counters, never from the upstream stream.
  assign w_sof     = (r_x == '0) && (r_y == '0);
  assign w_eol     = (r_x == c_last_x);
  assign w_eof     = w_eol && (r_y == c_last_y);
  assign w_in_word = {s_data, r_x, r_y, w_sof, w_eol, w_eof};

  // s_ready is only ever high with the skid empty, so an accept can never
  // collide with a pending skid entry.
  assign w_skid_valid_nxt = ~w_main_open & (r_skid_valid | w_in_xfer);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_x           <= '0;
      r_y           <= '0;
      r_main        <= '0;
      r_skid        <= '0;
      r_main_valid  <= 1'b0;
      r_skid_valid  <= 1'b0;
      r_s_ready     <= 1'b0;
      r_frame_done  <= 1'b0;
      r_frame_count <= '0;
    end else if (abort) begin
      r_state      <= ST_IDLE;
      r_x          <= '0;
      r_y          <= '0;
      r_main       <= '0;
      r_skid       <= '0;
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_s_ready    <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      if (w_main_open) begin
        if (r_skid_valid) begin
          r_main       <= r_skid;
          r_main_valid <= 1'b1;
        end else if (w_in_xfer) begin
          r_main       <= w_in_word;
          r_main_valid <= 1'b1;
        end else begin
          r_main_valid <= 1'b0;
        end
      end
      if (w_in_xfer && !w_main_open) begin
        r_skid <= w_in_word;
      end
      r_skid_valid <= w_skid_valid_nxt;
      r_frame_done <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state   <= ST_ACTIVE;
            r_x       <= '0;
            r_y       <= '0;
            r_s_ready <= 1'b1;
          end else begin
            r_s_ready <= 1'b0;
          end
        end
        ST_ACTIVE: begin
          r_s_ready <= ~w_skid_valid_nxt;
          if (w_in_xfer) begin
            if (w_eol) begin
              r_x <= '0;
              if (w_eof) begin
                r_y       <= '0;
                r_state   <= ST_DRAIN;
                r_s_ready <= 1'b0;
              end else begin
                r_y <= r_y + 1'b1;
              end
            end else begin
              r_x <= r_x + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          r_s_ready <= 1'b0;
          // The done cycle is spent in DRAIN so a start seen there is ignored.
          if (r_frame_done) begin
            r_state <= ST_IDLE;
          end else if (w_out_xfer && r_main[0]) begin
            r_frame_done  <= 1'b1;
            r_frame_count <= r_frame_count + 16'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign s_ready     = r_s_ready;
  assign m_valid     = r_main_valid;
  assign {m_data, m_x, m_y, m_sof, m_eol, m_eof} = r_main;
  assign busy        = (r_state != ST_IDLE);
  assign frame_done  = r_frame_done;
  assign frame_count = r_frame_count;

endmodule
`default_nettype wire
